// File: rtl/pad_pok_monitor.sv
// ---------------------------------------------------------------------------
// pad_pok_monitor
//
// Purpose:
//   Watches the per-IO-bank pad power-ok bits coming from the physical pad
//   layer. Each bit is brought into clk_i through a 2-flop synchroniser.
//   A bank is raw-good when all of its bits are 1. Each bank has a small
//   STABLE/FILTER debounce FSM. The FSM accepts a new level only after it
//   has held for DebounceCycles consecutive synchronised cycles. The block
//   reports a debounced per-bank power-good, rise/fall event pulses and a
//   sticky per-bank failure flag.
//
// Optional feature:
//   Define PAD_POK_MON_GLITCH_CNT_EN to add glitch_cnt_o. This is an 8-bit
//   saturating count, per bank, of rejected glitches. A rejected glitch is a
//   FILTER->STABLE return where the raw level comes back to the accepted
//   level before the debounce completes.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset (release expected synchronous)
//   pad_pok_i      asynchronous power-ok bits, bank b at [b*PokWidth +: PokWidth]
//   fail_clr_i     per-bank level clear of the sticky fail flag
//   bank_ok_o      debounced power-good per bank
//   all_ok_o       AND of bank_ok_o, registered alongside it
//   rise_o         one-cycle pulse when a bank's bank_ok_o goes 0->1
//   fall_o         one-cycle pulse when a bank's bank_ok_o goes 1->0
//   fail_sticky_o  set on a fall, held until fail_clr_i (set wins)
//   glitch_cnt_o   (PAD_POK_MON_GLITCH_CNT_EN only) 8 bits per bank
//
// Handshake note: there is no valid/ready flow here. Every input is sampled
// on every clock. Every pulse output is valid for exactly one clk_i cycle.
// ---------------------------------------------------------------------------
module pad_pok_monitor #(
    parameter int NIoBanks       = 4,
    parameter int PokWidth       = 2,
    parameter int DebounceCycles = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NIoBanks*PokWidth-1:0] pad_pok_i,
    input  logic [NIoBanks-1:0]          fail_clr_i,
    output logic [NIoBanks-1:0]          bank_ok_o,
    output logic                         all_ok_o,
    output logic [NIoBanks-1:0]          rise_o,
    output logic [NIoBanks-1:0]          fall_o,
    output logic [NIoBanks-1:0]          fail_sticky_o
`ifdef PAD_POK_MON_GLITCH_CNT_EN
    ,
    output logic [NIoBanks*8-1:0]        glitch_cnt_o
`endif
);

    localparam int                 CntW    = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0]    CntLast = CntW'(DebounceCycles - 1);
    localparam logic [CntW-1:0]    CntOne  = CntW'(1);

    typedef enum logic {
        STABLE = 1'b0,
        FILTER = 1'b1
    } deb_state_e;

    // -----------------------------------------------------------------------
    // 2-flop synchroniser, reset value 0
    // -----------------------------------------------------------------------
    logic [NIoBanks*PokWidth-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pad_pok_i;
            sync2_q <= sync1_q;
        end
    end

    logic [NIoBanks-1:0] raw_good;

    always_comb begin
        raw_good = '0;
        for (int b = 0; b < NIoBanks; b++) begin
            raw_good[b] = &sync2_q[b*PokWidth +: PokWidth];
        end
    end

    // -----------------------------------------------------------------------
    // Per-bank debounce FSM and event/flag registers
    // -----------------------------------------------------------------------
    deb_state_e          state_q [NIoBanks];
    deb_state_e          state_d [NIoBanks];
    logic [CntW-1:0]     cnt_q   [NIoBanks];
    logic [CntW-1:0]     cnt_d   [NIoBanks];

    logic [NIoBanks-1:0] bank_ok_q, bank_ok_d;
    logic [NIoBanks-1:0] rise_q, rise_d;
    logic [NIoBanks-1:0] fall_q, fall_d;
    logic [NIoBanks-1:0] sticky_q, sticky_d;
    logic                all_ok_q, all_ok_d;
    logic [NIoBanks-1:0] toggle;
    logic [NIoBanks-1:0] glitch;

    always_comb begin
        toggle = '0;
        glitch = '0;
        for (int b = 0; b < NIoBanks; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            unique case (state_q[b])
                STABLE: begin
                    cnt_d[b] = '0;
                    if (raw_good[b] != bank_ok_q[b]) begin
                        // With a one-cycle debounce the first mismatching
                        // sample is already enough, so FILTER is skipped.
                        if (DebounceCycles == 1) begin
                            toggle[b] = 1'b1;
                        end else begin
                            state_d[b] = FILTER;
                            cnt_d[b]   = CntOne;
                        end
                    end
                end
                FILTER: begin
                    if (raw_good[b] == bank_ok_q[b]) begin
                        state_d[b] = STABLE;
                        cnt_d[b]   = '0;
                        glitch[b]  = 1'b1;
                    end else if (cnt_q[b] == CntLast) begin
                        state_d[b] = STABLE;
                        cnt_d[b]   = '0;
                        toggle[b]  = 1'b1;
                    end else begin
                        cnt_d[b] = cnt_q[b] + CntOne;
                    end
                end
                default: begin
                    state_d[b] = STABLE;
                    cnt_d[b]   = '0;
                end
            endcase
        end

        bank_ok_d = bank_ok_q ^ toggle;
        rise_d    = toggle & ~bank_ok_q;
        fall_d    = toggle & bank_ok_q;
        // A fall in the same cycle as a clear keeps the flag set.
        sticky_d  = fall_d | (sticky_q & ~fail_clr_i);
        all_ok_d  = &bank_ok_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NIoBanks; b++) begin
                state_q[b] <= STABLE;
                cnt_q[b]   <= '0;
            end
            bank_ok_q <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            sticky_q  <= '0;
            all_ok_q  <= 1'b0;
        end else begin
            for (int b = 0; b < NIoBanks; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
            bank_ok_q <= bank_ok_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            sticky_q  <= sticky_d;
            all_ok_q  <= all_ok_d;
        end
    end

    assign bank_ok_o     = bank_ok_q;
    assign all_ok_o      = all_ok_q;
    assign rise_o        = rise_q;
    assign fall_o        = fall_q;
    assign fail_sticky_o = sticky_q;

`ifdef PAD_POK_MON_GLITCH_CNT_EN
    // -----------------------------------------------------------------------
    // Rejected-glitch counters
    // -----------------------------------------------------------------------
    logic [7:0] gcnt_q [NIoBanks];
    logic [7:0] gcnt_d [NIoBanks];
    logic [7:0] gcnt_base;

    always_comb begin
        gcnt_base = '0;
        for (int b = 0; b < NIoBanks; b++) begin
            gcnt_d[b] = gcnt_q[b];
            if (glitch[b]) begin
                // A clear and a glitch in the same cycle leave a count of 1.
                gcnt_base = fail_clr_i[b] ? 8'd0 : gcnt_q[b];
                gcnt_d[b] = (gcnt_base == 8'hFF) ? 8'hFF : gcnt_base + 8'd1;
            end else if (fail_clr_i[b]) begin
                gcnt_d[b] = 8'd0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NIoBanks; b++) begin
                gcnt_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NIoBanks; b++) begin
                gcnt_q[b] <= gcnt_d[b];
            end
        end
    end

    always_comb begin
        glitch_cnt_o = '0;
        for (int b = 0; b < NIoBanks; b++) begin
            glitch_cnt_o[b*8 +: 8] = gcnt_q[b];
        end
    end
`else
    logic unused_glitch;
    assign unused_glitch = ^glitch;
`endif

    // -----------------------------------------------------------------------
    // Assertions
    // -----------------------------------------------------------------------
    a_rise_fall_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rise_o & fall_o) == '0);

    a_sticky_only_on_fall: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((fail_sticky_o & ~$past(fail_sticky_o)) & ~fall_o) == '0);

    a_debounce_range: assert property (@(posedge clk_i)
        (DebounceCycles >= 1) && (DebounceCycles <= 255));

endmodule

// File: tb/tb_pad_pok_monitor.sv
// ---------------------------------------------------------------------------
// tb_pad_pok_monitor
//
// Directed bench for pad_pok_monitor with NIoBanks=4, PokWidth=2 and
// DebounceCycles=8. Inputs are driven and outputs are sampled on the falling
// edge of clk. A clean input edge therefore shows up on bank_ok_o after
// 10 falling edges.
// ---------------------------------------------------------------------------
module tb_pad_pok_monitor;

  localparam int NB  = 4;
  localparam int PW  = 2;
  localparam int DEB = 8;
  localparam int LAT = 2 + DEB;

  logic          clk;
  logic          rst_n;
  logic [NB*PW-1:0] pad_pok;
  logic [NB-1:0] fail_clr;
  logic [NB-1:0] bank_ok;
  logic          all_ok;
  logic [NB-1:0] rise;
  logic [NB-1:0] fall;
  logic [NB-1:0] sticky;
`ifdef PAD_POK_MON_GLITCH_CNT_EN
  logic [NB*8-1:0] glitch_cnt;
`endif

  int tests_run;
  int tests_failed;

  pad_pok_monitor #(
    .NIoBanks      (NB),
    .PokWidth      (PW),
    .DebounceCycles(DEB)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pad_pok_i    (pad_pok),
    .fail_clr_i   (fail_clr),
    .bank_ok_o    (bank_ok),
    .all_ok_o     (all_ok),
    .rise_o       (rise),
    .fall_o       (fall),
    .fail_sticky_o(sticky)
`ifdef PAD_POK_MON_GLITCH_CNT_EN
    ,
    .glitch_cnt_o (glitch_cnt)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] e_ok, input logic e_all,
                               input logic [3:0] e_rise, input logic [3:0] e_fall,
                               input logic [3:0] e_sticky);
    check_eq({tag, ".bank_ok"}, {28'd0, bank_ok}, {28'd0, e_ok});
    check_eq({tag, ".all_ok"},  {31'd0, all_ok},  {31'd0, e_all});
    check_eq({tag, ".rise"},    {28'd0, rise},    {28'd0, e_rise});
    check_eq({tag, ".fall"},    {28'd0, fall},    {28'd0, e_fall});
    check_eq({tag, ".sticky"},  {28'd0, sticky},  {28'd0, e_sticky});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    pad_pok  = 8'h00;
    fail_clr = 4'h0;

    // Reset state
    #1;
    check_outputs("reset", 4'h0, 1'b0, 4'h0, 4'h0, 4'h0);
`ifdef PAD_POK_MON_GLITCH_CNT_EN
    check_eq("reset.glitch_cnt", glitch_cnt, 32'h0);
`endif
    tick(2);
    rst_n = 1'b1;

    // 1) power-up: all banks good
    pad_pok = 8'hFF;
    tick(LAT - 1);
    check_outputs("pwrup_before", 4'h0, 1'b0, 4'h0, 4'h0, 4'h0);
    tick(1);
    check_outputs("pwrup_edge", 4'hF, 1'b1, 4'hF, 4'h0, 4'h0);
    tick(1);
    check_outputs("pwrup_after", 4'hF, 1'b1, 4'h0, 4'h0, 4'h0);

    // 2) 5-cycle glitch on bank 2 (bits [5:4] = 01) is rejected
    pad_pok = 8'hDF;
    tick(5);
    pad_pok = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check_outputs("glitch_b2", 4'hF, 1'b1, 4'h0, 4'h0, 4'h0);
    end
`ifdef PAD_POK_MON_GLITCH_CNT_EN
    check_eq("glitch_b2.cnt", glitch_cnt, 32'h0001_0000);
`endif

    // 3) bank 1 held at 2'b10 -> fall
    pad_pok = 8'hFB;
    tick(LAT - 1);
    check_outputs("fall_b1_before", 4'hF, 1'b1, 4'h0, 4'h0, 4'h0);
    tick(1);
    check_outputs("fall_b1_edge", 4'hD, 1'b0, 4'h0, 4'h2, 4'h2);
    tick(1);
    check_outputs("fall_b1_after", 4'hD, 1'b0, 4'h0, 4'h0, 4'h2);

    // 4) bank 1 recovers; the rise leaves sticky set
    pad_pok = 8'hFF;
    tick(LAT);
    check_outputs("rise_b1", 4'hF, 1'b1, 4'h2, 4'h0, 4'h2);
    tick(1);
    // next fall of bank 1 coincides with a clear: set wins
    pad_pok = 8'hFB;
    tick(LAT - 1);
    fail_clr = 4'h2;
    tick(1);
    fail_clr = 4'h0;
    check_outputs("fall_clr_same", 4'hD, 1'b0, 4'h0, 4'h2, 4'h2);
    tick(1);
    check_outputs("fall_clr_hold", 4'hD, 1'b0, 4'h0, 4'h0, 4'h2);
    fail_clr = 4'h2;
    tick(1);
    fail_clr = 4'h0;
    check_outputs("clr_alone", 4'hD, 1'b0, 4'h0, 4'h0, 4'h0);

    // 5) restore, then drop banks 0 and 3 together
    pad_pok = 8'hFF;
    tick(LAT);
    check_outputs("rise_b1_again", 4'hF, 1'b1, 4'h2, 4'h0, 4'h0);
    pad_pok = 8'h3D;
    tick(LAT);
    check_outputs("fall_b0_b3", 4'h6, 1'b0, 4'h0, 4'h9, 4'h9);
    tick(1);
    check_outputs("fall_b0_b3_after", 4'h6, 1'b0, 4'h0, 4'h0, 4'h9);

    // 6) reset in the middle of a bank-0 debounce
    pad_pok = 8'hFF;
    tick(LAT);
    check_outputs("restore_all", 4'hF, 1'b1, 4'h9, 4'h0, 4'h9);
    fail_clr = 4'hF;
    tick(1);
    fail_clr = 4'h0;
    check_outputs("clr_all", 4'hF, 1'b1, 4'h0, 4'h0, 4'h0);
    pad_pok = 8'hFC;
    tick(6);                          // bank 0 is now in FILTER with cnt=4
    check_outputs("mid_filter", 4'hF, 1'b1, 4'h0, 4'h0, 4'h0);
    pad_pok = 8'hFF;
    rst_n   = 1'b0;
    #1;
    check_outputs("mid_reset", 4'h0, 1'b0, 4'h0, 4'h0, 4'h0);
    tick(2);
    check_outputs("mid_reset_hold", 4'h0, 1'b0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      tick(1);
      check_outputs("requal_wait", 4'h0, 1'b0, 4'h0, 4'h0, 4'h0);
    end
    tick(1);
    check_outputs("requal_edge", 4'hF, 1'b1, 4'hF, 4'h0, 4'h0);
    tick(1);
    check_outputs("requal_after", 4'hF, 1'b1, 4'h0, 4'h0, 4'h0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
